// File: rtl/lfsr_rng.sv
// lfsr_rng: Fibonacci LFSR random source with free-running tick prescaler, seed load,
// lock-up recovery and a req/valid handshake. Define LFSR_RANGE_EN to reject values >= RANGE.
`timescale 1ns/1ps
module lfsr_rng #(
  parameter int                WIDTH = 16,
  parameter logic [WIDTH-1:0]  TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0]  SEED  = 16'h0001,
  parameter int                DIV   = 1000,
  parameter int                OUT_W = 2,
  parameter int                RANGE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  output logic             busy,
  output logic             rnd_valid,
  output logic [OUT_W-1:0] rnd,
  output logic [WIDTH-1:0] state
);

  localparam int             CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [OUT_W:0] RANGE_L = (OUT_W + 1)'(RANGE);

`ifdef LFSR_RANGE_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } hsState_e;

  logic [CNT_W-1:0] prescaleCnt_q, prescaleCnt_d;
  logic [WIDTH-1:0] lfsrState_q, lfsrState_d;
  logic [WIDTH-1:0] lfsrStep;
  logic             tick;
  logic             step;
  logic             feedback;
  logic             rangeOk;
  hsState_e         hsState_q, hsState_d;
  logic [OUT_W-1:0] rnd_q, rnd_d;
  logic             rndValid_q, rndValid_d;

  // Prescaler runs regardless of en or seed_load so the step cadence never drifts.
  always_comb begin
    tick          = (prescaleCnt_q == CNT_MAX);
    prescaleCnt_d = tick ? '0 : prescaleCnt_q + 1'b1;
  end

  // An all-zero state would stick forever, so a step from zero restarts at SEED.
  always_comb begin
    feedback = ^(lfsrState_q & TAPS);
    step     = tick & en & ~seed_load;
    if (lfsrState_q == '0) begin
      lfsrStep = SEED;
    end else begin
      lfsrStep = {lfsrState_q[WIDTH-2:0], feedback};
    end

    lfsrState_d = lfsrState_q;
    if (seed_load) begin
      lfsrState_d = (seed_in == '0) ? SEED : seed_in;
    end else if (step) begin
      lfsrState_d = lfsrStep;
    end
  end

  always_comb begin
    rangeOk = 1'b1;
    if (RANGE_EN) begin
      rangeOk = ({1'b0, lfsrStep[OUT_W-1:0]} < RANGE_L);
    end
  end

  // Handshake: a request is only ever served by a step strictly after acceptance.
  always_comb begin
    hsState_d  = hsState_q;
    rnd_d      = rnd_q;
    rndValid_d = 1'b0;
    case (hsState_q)
      IDLE: begin
        if (req) begin
          hsState_d = WAIT;
        end
      end
      WAIT: begin
        if (step && rangeOk) begin
          rnd_d      = lfsrStep[OUT_W-1:0];
          rndValid_d = 1'b1;
          hsState_d  = IDLE;
        end
      end
      default: hsState_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prescaleCnt_q <= '0;
      lfsrState_q   <= SEED;
      hsState_q     <= IDLE;
      rnd_q         <= '0;
      rndValid_q    <= 1'b0;
    end else begin
      prescaleCnt_q <= prescaleCnt_d;
      lfsrState_q   <= lfsrState_d;
      hsState_q     <= hsState_d;
      rnd_q         <= rnd_d;
      rndValid_q    <= rndValid_d;
    end
  end

  assign busy      = (hsState_q == WAIT);
  assign rnd_valid = rndValid_q;
  assign rnd       = rnd_q;
  assign state     = lfsrState_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// tb_lfsr_rng: vector table for the LFSR sequence plus scoreboarded handshake sequences.
// Expectations follow LFSR_RANGE_EN when the bench is built with that macro.
`timescale 1ns/1ps
module tb_lfsr_rng;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       seedLoad = 1'b0;
  logic [3:0] seedIn = 4'b0000;
  logic       req = 1'b0;
  logic       busy;
  logic       rndValid;
  logic [1:0] rnd;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  int edgeCount = 0;
  logic [1:0] expQ[$];

  typedef struct {
    logic       en;
    logic [3:0] expState;
  } vec_t;

  vec_t vecs[18];
  logic [3:0] seqTbl[15];

  always #5 clk = ~clk;

  lfsr_rng #(
    .WIDTH(4), .TAPS(4'b1100), .SEED(4'b0001), .DIV(4), .OUT_W(2), .RANGE(3)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .seed_load(seedLoad), .seed_in(seedIn), .req(req),
    .busy(busy), .rnd_valid(rndValid), .rnd(rnd), .state(state)
  );

  task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edgeCount);
    end
  endtask

  // Per-cycle monitor: exclusivity of busy/valid and scoreboard pop on every valid pulse.
  task automatic checkOutput();
    logic [1:0] e;
    checks++;
    if (busy === 1'b1 && rndValid === 1'b1) begin
      errors++;
      $display("[TB] FAIL busyValidExcl: busy=%b rnd_valid=%b, expected not both 1", busy, rndValid);
    end
    if (rndValid === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedValid: rnd_valid=1 rnd=%b at edge %0d, expected no pulse", rnd, edgeCount);
      end else begin
        e = expQ.pop_front();
        expectEq("scoreboardRnd", 32'(rnd), 32'(e));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    edgeCount++;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic enV, input logic loadV, input logic [3:0] seedV, input logic reqV);
    en       = enV;
    seedLoad = loadV;
    seedIn   = seedV;
    req      = reqV;
  endtask

  task automatic applyReset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    edgeCount = 0;
    expQ.delete();
    checkOutput();
  endtask

  task automatic waitServed(input int budget);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < budget) begin
      cycle();
      n++;
      if (expQ.size() == 0) req = 1'b0;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL serveTimeout: %0d values pending after %0d clk, expected 0", expQ.size(), budget);
      expQ.delete();
      req = 1'b0;
    end
  endtask

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] prev;

    seqTbl = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0101,
               4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};
    for (int i = 0; i < 15; i++) vecs[i] = '{1'b1, seqTbl[i]};
    vecs[15] = '{1'b0, 4'b0001};
    vecs[16] = '{1'b0, 4'b0001};
    vecs[17] = '{1'b1, 4'b0010};

    // Reset values, then the full period with en held, then frozen ticks.
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0);
    applyReset();
    expectEq("resetState", 32'(state), 32'h1);
    expectEq("resetRnd", 32'(rnd), 32'h0);
    expectEq("resetValid", 32'(rndValid), 32'h0);
    expectEq("resetBusy", 32'(busy), 32'h0);
    prev = 4'b0001;
    for (int i = 0; i < 18; i++) begin
      en = vecs[i].en;
      repeat (3) cycle();
      expectEq("preTickHold", 32'(state), 32'(prev));
      cycle();
      expectEq("lfsrStep", 32'(state), 32'(vecs[i].expState));
      prev = vecs[i].expState;
    end

    // Single request from 0001: served by the step to 0010.
    applyReset();
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1);
    expQ.push_back(2'b10);
    cycle();
    req = 1'b0;
    expectEq("busyAfterReq", 32'(busy), 32'h1);
    repeat (2) cycle();
    expectEq("busyHeld", 32'(busy), 32'h1);
    cycle();
    expectEq("validPulse", 32'(rndValid), 32'h1);
    expectEq("servedRnd", 32'(rnd), 32'h2);
    expectEq("servedBusy", 32'(busy), 32'h0);
    expectEq("servedState", 32'(state), 32'h2);
    cycle();
    expectEq("validOneClk", 32'(rndValid), 32'h0);
    expectEq("rndHeld", 32'(rnd), 32'h2);

    // Back-to-back requests: one value per step.
    applyReset();
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1);
    expQ.push_back(2'b10);
    expQ.push_back(2'b00);
    expQ.push_back(2'b01);
`ifdef LFSR_RANGE_EN
    expQ.push_back(2'b10);
`else
    expQ.push_back(2'b11);
`endif
    waitServed(40);
`ifdef LFSR_RANGE_EN
    expectEq("b2bLastEdge", 32'(edgeCount), 32'd20);
`else
    expectEq("b2bLastEdge", 32'(edgeCount), 32'd16);
`endif
    repeat (8) cycle();
    expectEq("b2bIdle", 32'(busy), 32'h0);

    // Seed loads: zero replaced by SEED, loaded value stepped, load beats a tick.
    applyReset();
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0);
    repeat (4) cycle();
    expectEq("preSeedState", 32'(state), 32'h2);
    applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0);
    cycle();
    expectEq("seedZero", 32'(state), 32'h1);
    seedIn = 4'b1010;
    cycle();
    expectEq("seedLoad", 32'(state), 32'hA);
    seedLoad = 1'b0;
    repeat (2) cycle();
    expectEq("seedThenStep", 32'(state), 32'h5);
    repeat (3) cycle();
    applyStimulus(1'b1, 1'b1, 4'b0110, 1'b0);
    cycle();
    expectEq("seedOnTick", 32'(state), 32'h6);
    seedLoad = 1'b0;
    cycle();
    expectEq("seedNoStep", 32'(state), 32'h6);
    repeat (3) cycle();
    expectEq("stepAfterSeed", 32'(state), 32'hD);
    req = 1'b1;
    expQ.push_back(2'b10);
    cycle();
    req = 1'b0;
    repeat (2) cycle();
    applyStimulus(1'b1, 1'b1, 4'b0011, 1'b0);
    cycle();
    expectEq("seedTickState", 32'(state), 32'h3);
    expectEq("seedTickNoServe", 32'(busy), 32'h1);
    seedLoad = 1'b0;
    waitServed(8);
    expectEq("seedServeEdge", 32'(edgeCount), 32'd24);
    expectEq("seedServeState", 32'(state), 32'h6);

    // Reset while waiting aborts the request.
    applyReset();
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1);
    cycle();
    req = 1'b0;
    expectEq("abortBusyBefore", 32'(busy), 32'h1);
    applyReset();
    expectEq("abortBusy", 32'(busy), 32'h0);
    repeat (12) cycle();
    expectEq("abortNoBusy", 32'(busy), 32'h0);
    expectEq("abortRnd", 32'(rnd), 32'h0);

    // Request from 0101: rejection path when the range limit is built in.
    applyReset();
    applyStimulus(1'b1, 1'b1, 4'b0101, 1'b0);
    cycle();
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1);
`ifdef LFSR_RANGE_EN
    expQ.push_back(2'b10);
`else
    expQ.push_back(2'b11);
`endif
    cycle();
    req = 1'b0;
    expectEq("rangeBusy", 32'(busy), 32'h1);
    waitServed(30);
`ifdef LFSR_RANGE_EN
    expectEq("rangeServeEdge", 32'(edgeCount), 32'd16);
    expectEq("rangeServeState", 32'(state), 32'hE);
    expectEq("rangeRnd", 32'(rnd), 32'h2);
`else
    expectEq("rangeServeEdge", 32'(edgeCount), 32'd4);
    expectEq("rangeServeState", 32'(state), 32'hB);
    expectEq("rangeRnd", 32'(rnd), 32'h3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
